// File: rtl/sub_128_seq_pkg.sv
// Shared constants and FSM state type for the sequential 128-bit subtractor.
package sub128_pkg;
  localparam int WIDTH  = 128;
  localparam int SLICE  = 24;
  localparam int NSLICE = (WIDTH + SLICE - 1) / SLICE;
  localparam int LAST_W = WIDTH - (NSLICE - 1) * SLICE;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/sub_128_seq_slice.sv
// Combinational W-bit subtract-with-borrow slice: d = a - b - bin, bout = 1 on underflow.
module sub_slice #(
  parameter int W = 24
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic [W-1:0] d,
  output logic         bout
);
  logic [W:0] ext;

  // One extra bit catches the underflow; its MSB is the borrow out.
  assign ext  = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
  assign d    = ext[W-1:0];
  assign bout = ext[W];
endmodule

// File: rtl/sub_128_seq.sv
// Sequential 128-bit subtractor: one slice per clock, borrow registered between slices,
// valid/ready handshakes on both sides.
module sub_128_seq
  import sub128_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);
  state_t            state, state_nx;
  logic [2:0]        idx;
  logic [WIDTH-1:0]  opa, opb;
  logic              brw;
  logic              last;
  logic [SLICE-1:0]  a_lo, b_lo, d_lo;
  logic              bout_lo;
  logic [LAST_W-1:0] d_hi;
  logic              bout_hi;

  assign last = (idx == 3'(NSLICE - 1));

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = RUN;
      end
      RUN: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Constant-index selection of the current low slice keeps every part-select in range.
  always_comb begin
    a_lo = '0;
    b_lo = '0;
    for (int i = 0; i < NSLICE - 1; i++) begin
      if (idx == 3'(i)) begin
        a_lo = opa[i*SLICE +: SLICE];
        b_lo = opb[i*SLICE +: SLICE];
      end
    end
  end

  sub_slice #(.W(SLICE)) u_slice_lo (
    .a    (a_lo),
    .b    (b_lo),
    .bin  (brw),
    .d    (d_lo),
    .bout (bout_lo)
  );

  sub_slice #(.W(LAST_W)) u_slice_hi (
    .a    (opa[WIDTH-1 -: LAST_W]),
    .b    (opb[WIDTH-1 -: LAST_W]),
    .bin  (brw),
    .d    (d_hi),
    .bout (bout_hi)
  );

  // Operand capture: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      opa <= a;
      opb <= b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      brw    <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && in_valid) begin
        idx <= '0;
        brw <= 1'b0;
      end else if (state == RUN) begin
        brw <= bout_lo;
        if (last) begin
          idx                     <= '0;
          diff[WIDTH-1 -: LAST_W] <= d_hi;
          borrow                  <= bout_hi;
        end else begin
          idx <= idx + 3'd1;
          for (int i = 0; i < NSLICE - 1; i++) begin
            if (idx == 3'(i)) diff[i*SLICE +: SLICE] <= d_lo;
          end
        end
      end
    end
  end
endmodule
